// File: rtl/video_pkg.sv
// Shared definitions for the RGB565 packer: pixel field positions, tkeep
// constants, packer state type and the 30-bit to RGB565 reduction.
package video_pkg;

    localparam int R_MSB = 29;
    localparam int R_LSB = 20;
    localparam int B_MSB = 19;
    localparam int B_LSB = 10;
    localparam int G_MSB = 9;
    localparam int G_LSB = 0;

    localparam logic [3:0] KEEP_FULL = 4'hF;
    localparam logic [3:0] KEEP_HALF = 4'h3;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } pack_state_t;

    // Plain truncation of each 10-bit component; no rounding.
    function automatic logic [15:0] rgb30_to_565(input logic [29:0] pix);
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
        r = pix[R_MSB:R_LSB];
        b = pix[B_MSB:B_LSB];
        g = pix[G_MSB:G_LSB];
        return {r[9:5], g[9:4], b[9:5]};
    endfunction

endpackage

// File: rtl/pack_out_reg.sv
// Output beat holding register for the RGB565 packer. Holds data stable
// while stalled and may reload in the same cycle it is drained.
module pack_out_reg
    import video_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [3:0]  load_keep,
    input  logic        load_last,
    input  logic        load_user,
    output logic        load_ready,
    output logic [31:0] m_tdata,
    output logic [3:0]  m_tkeep,
    output logic        m_tvalid,
    output logic        m_tlast,
    output logic        m_tuser,
    input  logic        m_tready
);

    assign load_ready = !m_tvalid || m_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tuser  <= 1'b0;
        end else if (load) begin
            m_tdata  <= load_data;
            m_tkeep  <= load_keep;
            m_tvalid <= 1'b1;
            m_tlast  <= load_last;
            m_tuser  <= load_user;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/video_rgb565_packer.sv
// Packs two RGB565 pixels per 32-bit AXI4-Stream beat, carrying SOF/EOL.
// Optional statistics (frames, lines, sync errors) built with PACK_STATS_EN.
//   state | meaning
//   EVEN  | no pixel held
//   ODD   | pix0 and its tuser held, waiting for pix1
module video_rgb565_packer
    import video_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axis_video_tdata,
    input  logic        s_axis_video_tvalid,
    output logic        s_axis_video_tready,
    input  logic        s_axis_video_tlast,
    input  logic        s_axis_video_tuser,
    output logic [31:0] m_axis_video_tdata,
    output logic [3:0]  m_axis_video_tkeep,
    output logic        m_axis_video_tvalid,
    input  logic        m_axis_video_tready,
    output logic        m_axis_video_tlast,
    output logic        m_axis_video_tuser,
    output logic [15:0] frame_cnt,
    output logic [11:0] last_line_cnt,
    output logic        sync_err
);

    pack_state_t state, state_nxt;
    logic        s_accept;
    logic [15:0] pix565;
    logic [15:0] hold_pix;
    logic        hold_user;
    logic        hold_we;
    logic        drop_held;
    logic        ld;
    logic [31:0] ld_data;
    logic [3:0]  ld_keep;
    logic        ld_last;
    logic        ld_user;
    logic [1:0]  tdata_pad;

    assign tdata_pad = s_axis_video_tdata[31:30];
    assign pix565    = rgb30_to_565(s_axis_video_tdata[29:0]);
    assign s_accept  = s_axis_video_tvalid && s_axis_video_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EVEN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (s_accept) begin
            if (s_axis_video_tlast || (state == ODD && !s_axis_video_tuser))
                state_nxt = EVEN;
            else
                state_nxt = ODD;
        end
    end

    // A tuser arriving in ODD restarts pairing: held pixel is discarded.
    always_comb begin
        ld        = 1'b0;
        ld_data   = '0;
        ld_keep   = '0;
        ld_last   = 1'b0;
        ld_user   = 1'b0;
        hold_we   = 1'b0;
        drop_held = 1'b0;
        if (s_accept) begin
            if (state == ODD && !s_axis_video_tuser) begin
                ld      = 1'b1;
                ld_data = {pix565, hold_pix};
                ld_keep = KEEP_FULL;
                ld_last = s_axis_video_tlast;
                ld_user = hold_user | s_axis_video_tuser;
            end else begin
                drop_held = (state == ODD);
                if (s_axis_video_tlast) begin
                    ld      = 1'b1;
                    ld_data = {16'h0000, pix565};
                    ld_keep = KEEP_HALF;
                    ld_last = 1'b1;
                    ld_user = s_axis_video_tuser;
                end else begin
                    hold_we = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_pix  <= '0;
            hold_user <= 1'b0;
        end else if (hold_we) begin
            hold_pix  <= pix565;
            hold_user <= s_axis_video_tuser;
        end
    end

    pack_out_reg u_out (
        .clk        (clk),
        .rst        (rst),
        .load       (ld),
        .load_data  (ld_data),
        .load_keep  (ld_keep),
        .load_last  (ld_last),
        .load_user  (ld_user),
        .load_ready (s_axis_video_tready),
        .m_tdata    (m_axis_video_tdata),
        .m_tkeep    (m_axis_video_tkeep),
        .m_tvalid   (m_axis_video_tvalid),
        .m_tlast    (m_axis_video_tlast),
        .m_tuser    (m_axis_video_tuser),
        .m_tready   (m_axis_video_tready)
    );

`ifdef PACK_STATS_EN
    logic [11:0] line_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt     <= '0;
            line_cnt      <= '0;
            last_line_cnt <= '0;
            sync_err      <= 1'b0;
        end else begin
            if (drop_held) sync_err <= 1'b1;
            if (s_accept && s_axis_video_tuser) begin
                frame_cnt     <= frame_cnt + 16'd1;
                last_line_cnt <= line_cnt;
                line_cnt      <= s_axis_video_tlast ? 12'd1 : 12'd0;
            end else if (s_accept && s_axis_video_tlast) begin
                line_cnt <= line_cnt + 12'd1;
            end
        end
    end
`else
    logic unused_stats;
    assign unused_stats  = drop_held ^ ^tdata_pad;
    assign frame_cnt     = '0;
    assign last_line_cnt = '0;
    assign sync_err      = 1'b0;
`endif

endmodule

// File: tb/tb_video_rgb565_packer.sv
// Scoreboard bench for video_rgb565_packer: directed pixels push expected
// beats; a negedge monitor pops and compares on every output handshake.
module tb_video_rgb565_packer;

`ifdef PACK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tready, s_tlast, s_tuser;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid, m_tready, m_tlast, m_tuser;
    logic [15:0] frame_cnt;
    logic [11:0] last_line_cnt;
    logic        sync_err;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        u;
    } beat_t;

    beat_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    video_rgb565_packer dut (
        .clk                 (clk),
        .rst                 (rst),
        .s_axis_video_tdata  (s_tdata),
        .s_axis_video_tvalid (s_tvalid),
        .s_axis_video_tready (s_tready),
        .s_axis_video_tlast  (s_tlast),
        .s_axis_video_tuser  (s_tuser),
        .m_axis_video_tdata  (m_tdata),
        .m_axis_video_tkeep  (m_tkeep),
        .m_axis_video_tvalid (m_tvalid),
        .m_axis_video_tready (m_tready),
        .m_axis_video_tlast  (m_tlast),
        .m_axis_video_tuser  (m_tuser),
        .frame_cnt           (frame_cnt),
        .last_line_cnt       (last_line_cnt),
        .sync_err            (sync_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Input word whose RGB565 reduction is exactly {r, g, b}.
    function automatic logic [31:0] px(input logic [4:0] r, input logic [5:0] g, input logic [4:0] b);
        return {2'b00, r, 5'b0, b, 5'b0, g, 4'b0};
    endfunction

    function automatic logic [15:0] p565(input logic [4:0] r, input logic [5:0] g, input logic [4:0] b);
        return {r, g, b};
    endfunction

    task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
        beat_t b;
        b.d = d; b.k = k; b.l = l; b.u = u;
        exp_q.push_back(b);
    endtask

    task automatic send(input logic [31:0] d, input logic u, input logic l);
        int t;
        t = 0;
        s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            t++;
            if (t > 50) begin
                check("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: handshake compare and stall-stability check.
    logic        stall_seen = 1'b0;
    logic [31:0] stall_data;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen && m_tvalid) check("stall_data_stable", m_tdata, stall_data);
            if (m_tvalid && !m_tready) begin
                stall_seen = 1'b1;
                stall_data = m_tdata;
            end else begin
                stall_seen = 1'b0;
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", m_tdata, 32'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", m_tdata, e.d);
                    check("beat_keep", {28'd0, m_tkeep}, {28'd0, e.k});
                    check("beat_last", {31'd0, m_tlast}, {31'd0, e.l});
                    check("beat_user", {31'd0, m_tuser}, {31'd0, e.u});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tuser = 1'b0; m_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst_s_tready", {31'd0, s_tready}, 32'd1);
        check("rst_m_tdata", m_tdata, 32'd0);
        check("rst_m_tkeep", {28'd0, m_tkeep}, 32'd0);
        check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check("rst_sync_err", {31'd0, sync_err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Two-pixel beat, SOF on first pixel
        push(32'h07E0_F81F, 4'hF, 1'b0, 1'b1);
        send(32'h3FFF_FC00, 1'b1, 1'b0);
        check("lat_after_pix0", {31'd0, m_tvalid}, 32'd0);
        send(32'h0000_03FF, 1'b0, 1'b0);
        check("lat_after_pix1", {31'd0, m_tvalid}, 32'd1);
        drain();

        // Odd-length line ends with a padded beat
        push(32'hF81F_F81F, 4'hF, 1'b0, 1'b0);
        push(32'h0000_F81F, 4'h3, 1'b1, 1'b0);
        send(32'h3FFF_FC00, 1'b0, 1'b0);
        send(32'h3FFF_FC00, 1'b0, 1'b0);
        send(32'h3FFF_FC00, 1'b0, 1'b1);
        drain();

        // Output stall with continuous input
        push({p565(5'd2, 6'd2, 5'd2), p565(5'd1, 6'd1, 5'd1)}, 4'hF, 1'b0, 1'b0);
        push({p565(5'd4, 6'd4, 5'd4), p565(5'd3, 6'd3, 5'd3)}, 4'hF, 1'b0, 1'b0);
        push({p565(5'd6, 6'd6, 5'd6), p565(5'd5, 6'd5, 5'd5)}, 4'hF, 1'b1, 1'b0);
        m_tready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++)
                    send(px(5'(i), 6'(i), 5'(i)), 1'b0, i == 6);
            end
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                check("stall_s_tready_low", {31'd0, s_tready}, 32'd0);
                check("stall_m_tvalid_high", {31'd0, m_tvalid}, 32'd1);
                @(posedge clk); #1;
                m_tready = 1'b1;
            end
        join
        drain();

        // SOF mid-word drops the held pixel
        push({p565(5'd5, 6'd5, 5'd5), p565(5'd4, 6'd4, 5'd4)}, 4'hF, 1'b1, 1'b1);
        send(px(5'd3, 6'd3, 5'd3), 1'b0, 1'b0);
        send(px(5'd4, 6'd4, 5'd4), 1'b1, 1'b0);
        send(px(5'd5, 6'd5, 5'd5), 1'b0, 1'b1);
        drain();
        check("sync_err_set", {31'd0, sync_err}, {31'd0, STATS});

        // Fresh reset, then two 4x4 frames and a third SOF
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst2_sync_err", {31'd0, sync_err}, 32'd0);
        for (int f = 0; f < 2; f++) begin
            for (int l = 0; l < 4; l++) begin
                push({p565(5'(f*4+l), 6'd2, 5'(l)), p565(5'(f*4+l), 6'd1, 5'(l))}, 4'hF, 1'b0, l == 0);
                push({p565(5'(f*4+l), 6'd4, 5'(l)), p565(5'(f*4+l), 6'd3, 5'(l))}, 4'hF, 1'b1, 1'b0);
                for (int p = 0; p < 4; p++)
                    send(px(5'(f*4+l), 6'(p+1), 5'(l)), (l == 0) && (p == 0), p == 3);
            end
        end
        push({16'h0000, p565(5'd31, 6'd63, 5'd31)}, 4'h3, 1'b1, 1'b1);
        send(px(5'd31, 6'd63, 5'd31), 1'b1, 1'b1);
        drain();
        check("frame_cnt", {16'd0, frame_cnt}, STATS ? 32'd3 : 32'd0);
        check("last_line_cnt", {20'd0, last_line_cnt}, STATS ? 32'd4 : 32'd0);
        check("sync_err_clean", {31'd0, sync_err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/video_rgb565_packer.md
# video_rgb565_packer

Downstream stage of the synthetic-picture/pass-through video mux in the drone camera pipeline. It takes the 30-bit packed pixel stream on AXI4-Stream, reduces each pixel to RGB565 and packs two pixels per 32-bit output beat, halving link bandwidth toward the DMA/transmit path. SOF (`tuser`) and EOL (`tlast`) markers are carried across. An optional statistics section counts frames, lines and sync errors.

## Interface
- No parameters. Widths are fixed by the shared package.
- `clk` in 1: single clock for all logic.
- `rst` in 1: asynchronous, active-high reset.
- `s_axis_video_tdata` in 32: input pixel `{2'b00, R[29:20], B[19:10], G[9:0]}`.
- `s_axis_video_tvalid` in 1: input valid.
- `s_axis_video_tready` out 1: input ready.
- `s_axis_video_tlast` in 1: end of line.
- `s_axis_video_tuser` in 1: start of frame, marks the first pixel.
- `m_axis_video_tdata` out 32: `{pix1_565, pix0_565}`. `pix0` is the earlier pixel.
- `m_axis_video_tkeep` out 4: `4'hF` for a full beat, `4'h3` for a padded beat.
- `m_axis_video_tvalid` out 1: output valid.
- `m_axis_video_tready` in 1: output ready.
- `m_axis_video_tlast` out 1: end of line.
- `m_axis_video_tuser` out 1: start of frame.
- `frame_cnt` out 16: frames seen. Statistics output.
- `last_line_cnt` out 12: lines in the last completed frame. Statistics output.
- `sync_err` out 1: sticky flag for a dropped half-word. Statistics output.

## Operation
- Conversion per pixel: `565 = {R[9:5], G[9:4], B[9:5]}`, plain truncation, no rounding.
- State machine with two states:
  - EVEN: no pixel held.
  - ODD: `pix0` held in the hold register, along with its `tuser` bit.
- EVEN, input accepted:
  - Without `tlast`: store pixel and its `tuser`, go to ODD.
  - With `tlast`: load output as `{16'h0000, pix}`, `tkeep=4'h3`, `tlast=1`, `tuser=` the input `tuser`. Stay in EVEN.
- ODD, input accepted without `tuser`:
  - Load output as `{pix, held}`, `tkeep=4'hF`.
  - `tlast` = input `tlast`.
  - `tuser` = held `tuser` OR'd with input `tuser`.
  - Go to EVEN.
- ODD, input accepted with `tuser` (a new frame started mid-word):
  - Discard the held pixel and set `sync_err`.
  - Treat the new pixel exactly as in EVEN.
- Output register:
  - Loads only on input acceptance as defined above.
  - Holds data stable while `tvalid=1` and `tready=0`.
- Ready: `s_axis_video_tready = !m_axis_video_tvalid || m_axis_video_tready`, in both states.
- Reset values:
  - Outputs: `m_axis_video_tvalid=0`, `tdata=0`, `tkeep=0`, `tlast=0`, `tuser=0`.
  - Statistics outputs: 0.
  - State machine: EVEN.
  - `s_axis_video_tready=1` during and after reset.
- Reset asserted mid-frame: the held pixel and the pending output beat are lost. The next frame is expected to begin with `tuser`.

## Timing
- Latency: output valid one cycle after acceptance of the completing pixel. The completing pixel is the second pixel, or a `tlast` pixel in EVEN.
- Throughput: one input pixel per cycle while output is ready, giving an output beat every two cycles.
- Input `tuser` and `tlast` on the same pixel (a one-pixel line): one padded beat with both `tuser=1` and `tlast=1`.
- Back-to-back full beats: the output register may reload in the same cycle it is drained (`tvalid & tready`).
- Counters: 16/12-bit wrapping counters. No saturation.

## Configuration
- Macro: `PACK_STATS_EN`.
- Defined:
  - `frame_cnt` increments on each accepted `tuser` pixel.
  - A line counter increments on each accepted `tlast` pixel and clears on `tuser`.
  - On `tuser`, `last_line_cnt` captures the line count of the frame just ended.
  - `sync_err` is sticky until reset.
- Undefined: the three ports remain present, are tied to 0, and no counter flops are built.

## Structure
- Shared package `video_pkg` holds:
  - Field positions: `R_MSB/LSB`, `B_MSB/LSB`, `G_MSB/LSB`.
  - Constants `KEEP_FULL=4'hF` and `KEEP_HALF=4'h3`.
  - The state typedef (EVEN/ODD).
  - Function `rgb30_to_565`.
- One sub-module: `pack_out_reg`, the output data/valid holding register with its ready logic.

## Test plan
- Reset held 3 cycles: `m_tvalid=0`, `s_tready=1`, `frame_cnt=0`, `sync_err=0`.
- Send `0x3FFFFC00` then `0x000003FF` (`tuser` on first), `m_tready=1` -> one beat `0x07E0F81F`, `tkeep=F`, `tuser=1`, `tlast=0`, one cycle after the second pixel.
- 3-pixel line `0x3FFFFC00` ×3, `tlast` on the third -> beat `0xF81FF81F` (`tkeep=F`), then `0x0000F81F` (`tkeep=3`, `tlast=1`).
- `m_tready=0` for 5 cycles with continuous input -> `s_tready` drops once the output is full, data stays stable, and every pixel appears in order afterwards.
- One pixel without `tlast`, then a pixel with `tuser` -> held pixel dropped, next beat has `tuser=1`, `sync_err=1` (`PACK_STATS_EN`).
- Two frames of 4 lines × 4 pixels, then a third `tuser` -> `frame_cnt=3`, `last_line_cnt=4`. Without the macro, all statistics ports stay 0.
